hazard_exc_ctrl: RTL and testbench

- Pipeline control unit for the five-stage MIPS core (F/D/E/M/W).
- Generates the D-stage stall, the E-stage bubble and the global exception/interrupt flush (IntReq) consumed by every pipeline register, including the E/M register.
- Sequences the multi-cycle multiply/divide unit (MDU) with a busy FSM.
- Supplies EPC, cause code and BD to CP0.

---
 rtl/hazard_exc_ctrl.sv | 81 ++++++++
 tb/tb_hazard_exc_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/hazard_exc_ctrl.sv
// hazard_exc_ctrl: D-stall, MDU busy sequencing, exception flush and CP0 record for a 5-stage MIPS (stall counter under HAZARD_STALL_STATS_EN)
module hazard_exc_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  input  logic [1:0]  D_rs_tuse,
  input  logic [1:0]  D_rt_tuse,
  input  logic        D_is_md,
  input  logic        D_eret,
  input  logic [4:0]  E_wa,
  input  logic [1:0]  E_tnew,
  input  logic        E_mtc0_epc,
  input  logic [4:0]  M_wa,
  input  logic [1:0]  M_tnew,
  input  logic        M_mtc0_epc,
  input  logic        E_md_start,
  input  logic        E_md_div,
  input  logic [31:0] M_PC,
  input  logic [4:0]  M_ExcCode,
  input  logic        M_isdb,
  input  logic        int_pending,
  output logic        stall,
  output logic        IntReq,
  output logic        md_busy,
  output logic        md_go,
  output logic [31:0] cp0_epc,
  output logic [4:0]  cp0_exc,
  output logic        cp0_bd,
  output logic [31:0] stall_count
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MC = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DC = CW'(DIV_CYCLES);
  typedef enum logic [0:0] {IDLE, BUSY} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic stall_rs, stall_rt, stall_md, stall_eret;
  // hazard detection, MDU handshake and exception reporting
  always_comb begin
    stall_rs   = |D_rs_addr & ((D_rs_addr == E_wa & E_tnew > D_rs_tuse) | (D_rs_addr == M_wa & M_tnew > D_rs_tuse));
    stall_rt   = |D_rt_addr & ((D_rt_addr == E_wa & E_tnew > D_rt_tuse) | (D_rt_addr == M_wa & M_tnew > D_rt_tuse));
    IntReq     = !reset & (|M_ExcCode | int_pending);
    md_go      = state == IDLE & E_md_start & !IntReq;
    md_busy    = state == BUSY | E_md_start;
    stall_md   = D_is_md & md_busy;
    stall_eret = D_eret & (E_mtc0_epc | M_mtc0_epc);
    stall      = !IntReq & (stall_rs | stall_rt | stall_md | stall_eret);
    cp0_epc    = M_isdb ? M_PC - 32'd4 : M_PC;
    cp0_exc    = M_ExcCode;
    cp0_bd     = M_isdb;
  end
  // MDU busy FSM; a running op keeps counting through a flush
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (md_go) begin
        state <= BUSY;
        cnt   <= E_md_div ? DC : MC;
      end
    end else begin
      state <= cnt == CW'(1) ? IDLE : BUSY;
      cnt   <= cnt - CW'(1);
    end
  end
`ifdef HAZARD_STALL_STATS_EN
  // stall-cycle statistics, wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (reset) stall_count <= '0;
    else if (stall) stall_count <= stall_count + 32'd1;
  end
`else
  assign stall_count = '0;
`endif
endmodule

// File: tb/tb_hazard_exc_ctrl.sv
// tb_hazard_exc_ctrl: directed self-checking bench for hazard_exc_ctrl
module tb_hazard_exc_ctrl;
  logic clk = 0, reset;
  logic [4:0] D_rs_addr, D_rt_addr, E_wa, M_wa, M_ExcCode;
  logic [1:0] D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
  logic D_is_md, D_eret, E_mtc0_epc, M_mtc0_epc, E_md_start, E_md_div, M_isdb, int_pending;
  logic [31:0] M_PC;
  logic stall, IntReq, md_busy, md_go, cp0_bd;
  logic [31:0] cp0_epc, stall_count;
  logic [4:0] cp0_exc;
  int checks = 0, errors = 0;
  hazard_exc_ctrl dut (
    .clk(clk), .reset(reset), .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
    .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse), .D_is_md(D_is_md), .D_eret(D_eret),
    .E_wa(E_wa), .E_tnew(E_tnew), .E_mtc0_epc(E_mtc0_epc), .M_wa(M_wa), .M_tnew(M_tnew),
    .M_mtc0_epc(M_mtc0_epc), .E_md_start(E_md_start), .E_md_div(E_md_div), .M_PC(M_PC),
    .M_ExcCode(M_ExcCode), .M_isdb(M_isdb), .int_pending(int_pending), .stall(stall),
    .IntReq(IntReq), .md_busy(md_busy), .md_go(md_go), .cp0_epc(cp0_epc),
    .cp0_exc(cp0_exc), .cp0_bd(cp0_bd), .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    D_rs_addr = 0; D_rt_addr = 0; D_rs_tuse = 3; D_rt_tuse = 3; D_is_md = 0; D_eret = 0;
    E_wa = 0; E_tnew = 0; E_mtc0_epc = 0; M_wa = 0; M_tnew = 0; M_mtc0_epc = 0;
    E_md_start = 0; E_md_div = 0; M_PC = 0; M_ExcCode = 0; M_isdb = 0; int_pending = 0;
  endtask
  task automatic md_seq(input logic div, input int n, input string tag);
    E_md_start = 1; E_md_div = div; D_is_md = 1; #1;
    chk({tag, "_go"}, md_go, 1);
    chk({tag, "_busy_t"}, md_busy, 1);
    chk({tag, "_stall_t"}, stall, 1);
    tick();
    E_md_start = 0; E_md_div = 0;
    for (int i = 1; i <= n; i++) begin
      #1;
      chk({tag, "_busy"}, md_busy, 1);
      chk({tag, "_stall"}, stall, 1);
      tick();
    end
    #1;
    chk({tag, "_busy_end"}, md_busy, 0);
    chk({tag, "_stall_end"}, stall, 0);
    D_is_md = 0;
  endtask
  initial begin
    idle_inputs();
    reset = 1;
    tick(); tick();
    chk("rst_intreq", IntReq, 0);
    chk("rst_busy", md_busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_count", stall_count, 0);
    M_ExcCode = 4; #1;
    chk("rst_masks_intreq", IntReq, 0);
    M_ExcCode = 0;
    reset = 0; tick();
    E_wa = 8; E_tnew = 2; D_rs_addr = 8; D_rs_tuse = 1; #1;
    chk("loaduse_stall", stall, 1);
    tick();
    E_wa = 0; E_tnew = 0; M_wa = 8; M_tnew = 1; #1;
    chk("loaduse_release", stall, 0);
    D_rs_tuse = 0; #1;
    chk("m_hazard_tuse0", stall, 1);
    D_rs_tuse = 3; M_tnew = 3; #1;
    chk("tuse3_nostall", stall, 0);
    idle_inputs();
    D_rt_addr = 9; D_rt_tuse = 0; E_wa = 9; E_tnew = 1; #1;
    chk("rt_stall", stall, 1);
    idle_inputs();
    E_wa = 0; D_rs_addr = 0; E_tnew = 2; D_rs_tuse = 0; #1;
    chk("zero_reg", stall, 0);
    idle_inputs(); tick();
    md_seq(0, 5, "mult");
    tick();
    md_seq(1, 10, "div");
    idle_inputs();
    M_ExcCode = 4; M_isdb = 1; M_PC = 32'h3010;
    E_wa = 8; E_tnew = 2; D_rs_addr = 8; D_rs_tuse = 1; #1;
    chk("exc_intreq", IntReq, 1);
    chk("exc_epc", cp0_epc, 32'h300C);
    chk("exc_code", cp0_exc, 4);
    chk("exc_bd", cp0_bd, 1);
    chk("exc_stall_masked", stall, 0);
    M_isdb = 0; M_ExcCode = 10; int_pending = 1; #1;
    chk("exc_epc_nodb", cp0_epc, 32'h3010);
    chk("exc_bd0", cp0_bd, 0);
    chk("exc_prio", cp0_exc, 10);
    idle_inputs();
    int_pending = 1; E_md_start = 1; #1;
    chk("int_intreq", IntReq, 1);
    chk("int_exc0", cp0_exc, 0);
    chk("int_go_dropped", md_go, 0);
    tick();
    idle_inputs(); #1;
    chk("int_fsm_idle", md_busy, 0);
    E_md_start = 1; tick();
    E_md_start = 0; int_pending = 1; tick(); tick();
    #1;
    chk("busy_through_int", md_busy, 1);
    int_pending = 0; tick(); tick(); tick();
    #1;
    chk("busy_done_after_int", md_busy, 0);
    E_md_start = 1; tick();
    E_md_start = 0; tick();
    reset = 1; tick();
    reset = 0; #1;
    chk("rst_mid_busy", md_busy, 0);
    idle_inputs();
    reset = 1; tick();
    reset = 0; #1;
    D_eret = 1; M_mtc0_epc = 1; #1;
    chk("eret_stall", stall, 1);
    tick();
    M_mtc0_epc = 0; #1;
    chk("eret_release", stall, 0);
`ifdef HAZARD_STALL_STATS_EN
    chk("stall_count", stall_count, 1);
`else
    chk("stall_count", stall_count, 0);
`endif
    E_mtc0_epc = 1; #1;
    chk("eret_stall_e", stall, 1);
    idle_inputs(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
